// File: rtl/countdown_timer4_pkg.sv
// Shared definitions for the loadable countdown timer.
// State encodings and default counter width.
package countdown_timer4_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer4.sv
// Loadable down-counter with one-shot and auto-reload modes.
// Flags terminal count with a single-cycle registered tc pulse.
module countdown_timer4
    import countdown_timer4_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic             at_term;

    // A running count is always >= 1, so reaching 1 is the terminal step
    assign at_term = (cnt_q == WIDTH'(1));

    // Next-state logic: load beats counting; tc is a one-cycle pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (load) begin
            cnt_d   = load_val;
            rld_d   = load_val;
            state_d = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en) begin
                        if (at_term) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                cnt_d = rld_q;
                            end else begin
                                cnt_d   = '0;
                                state_d = ST_DONE;
                            end
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, reload and tc registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    assign q    = cnt_q;
    assign tc   = tc_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_countdown_timer4.sv
// Directed self-checking bench for countdown_timer4.
// Each scenario task drives stimulus and checks outputs inline.
module tb_countdown_timer4;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       auto_reload;
    logic [3:0] q;
    logic       tc;
    logic       busy;

    int n_cmp;
    int n_bad;

    countdown_timer4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; load_val = 4'd7;
        en = 1'b1; auto_reload = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_held q=%0d tc=%0b busy=%0b want 0/0/0", q, tc, busy);
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
        tick();
        n_cmp++;
        if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release q=%0d tc=%0b busy=%0b want 0/0/0", q, tc, busy);
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] eq;
        logic       etc, eb;
        load = 1'b1; load_val = 4'd5; auto_reload = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++;
        if (q !== 4'd5 || tc !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL oneshot_load q=%0d tc=%0b busy=%0b want 5/0/1", q, tc, busy);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            eq  = 4'(5 - k);
            etc = (k == 5);
            eb  = (k < 5);
            n_cmp++;
            if (q !== eq || tc !== etc || busy !== eb) begin
                n_bad++;
                $display("FAIL oneshot_step%0d q=%0d tc=%0b busy=%0b want %0d/%0b/%0b",
                         k, q, tc, busy, eq, etc, eb);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL oneshot_idle%0d q=%0d tc=%0b busy=%0b want 0/0/0",
                         k, q, tc, busy);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_autoreload();
        int         pulses;
        logic [3:0] eq;
        logic       etc;
        pulses = 0;
        load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            etc = ((i % 3) == 0);
            eq  = etc ? 4'd3 : 4'(3 - (i % 3));
            if (tc === 1'b1) pulses++;
            n_cmp++;
            if (q !== eq || tc !== etc || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL reload_step%0d q=%0d tc=%0b busy=%0b want %0d/%0b/1",
                         i, q, tc, busy, eq, etc);
            end
        end
        n_cmp++;
        if (pulses != 4) begin
            n_bad++;
            $display("FAIL reload_pulses got=%0d want=4", pulses);
        end
        en = 1'b0;
    endtask

    task automatic test_enable_gating();
        logic [5:0] pat;
        logic [3:0] eqs [6];
        logic [3:0] eq;
        logic       etc;
        pat = 6'b111001;
        eqs = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
        load = 1'b1; load_val = 4'd4; auto_reload = 1'b0; en = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en = pat[i];
            tick();
            eq  = eqs[i];
            etc = (i == 5);
            n_cmp++;
            if (q !== eq || tc !== etc) begin
                n_bad++;
                $display("FAIL gate_step%0d q=%0d tc=%0b want %0d/%0b",
                         i, q, tc, eq, etc);
            end
        end
        en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_zero_load();
        load = 1'b1; load_val = 4'd0; auto_reload = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++;
        if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_load q=%0d tc=%0b busy=%0b want 0/0/0", q, tc, busy);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (tc !== 1'b0 || busy !== 1'b0 || q !== 4'd0) begin
                n_bad++;
                $display("FAIL zero_idle%0d q=%0d tc=%0b busy=%0b want 0/0/0",
                         k, q, tc, busy);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        load = 1'b1; load_val = 4'd6; auto_reload = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_cmp++;
        if (q !== 4'd1 || busy !== 1'b1 || tc !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_at_one q=%0d tc=%0b busy=%0b want 1/0/1", q, tc, busy);
        end
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0;
        n_cmp++;
        if (q !== 4'd9 || tc !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_reload q=%0d tc=%0b busy=%0b want 9/0/1", q, tc, busy);
        end
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if (q !== 4'd5 || tc !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_at_five q=%0d tc=%0b busy=%0b want 5/0/1", q, tc, busy);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_rst q=%0d tc=%0b busy=%0b want 0/0/0", q, tc, busy);
        end
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_post_rst q=%0d tc=%0b busy=%0b want 0/0/0", q, tc, busy);
        end
        en = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; load = 1'b0; load_val = 4'd0;
        en = 1'b0; auto_reload = 1'b0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_enable_gating();
        test_zero_load();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
